algo_1r2wg_req_sched: RTL and testbench

- Request scheduler in front of the 1-read/2-write-gated multiport memory top.
- Shares the memory's 1 read port and NUMWRPT=2 write ports among NUMREQ requesters using round-robin arbitration.
- Defers a second write in the same cycle when it targets the same address as the first.
- Tracks outstanding reads with a tag pipeline and steers each read return back to the requester that issued it.

---
 rtl/algo_1r2wg_req_sched.sv | 200 ++++++++++++++++++++
 tb/tb_algo_1r2wg_req_sched.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/algo_1r2wg_req_sched.sv
// Request scheduler for the 1-read / 2-write-gated memory top.
// NUMREQ requesters share the single read port and both write ports through
// round-robin arbitration. A tag pipeline remembers which requester issued
// each read so that the return can be steered back to it.
module algo_1r2wg_req_sched #(
    parameter int WIDTH    = 32,
    parameter int NUMADDR  = 8192,
    parameter int BITADDR  = 13,
    parameter int NUMWRPT  = 2,
    parameter int NUMREQ   = 4,
    parameter int BITREQ   = 2,
    parameter int RD_DELAY = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ready,
    input  logic [NUMREQ-1:0]          rq_read,
    input  logic [NUMREQ-1:0]          rq_write,
    input  logic [NUMREQ*BITADDR-1:0]  rq_adr,
    input  logic [NUMREQ*WIDTH-1:0]    rq_din,
    output logic [NUMREQ-1:0]          rq_gnt,
    output logic                       read,
    output logic [BITADDR-1:0]         rd_adr,
    output logic [NUMWRPT-1:0]         write,
    output logic [NUMWRPT*BITADDR-1:0] wr_adr,
    output logic [NUMWRPT*WIDTH-1:0]   din,
    input  logic                       rd_vld,
    input  logic [WIDTH-1:0]           rd_dout,
    output logic [NUMREQ-1:0]          rsp_vld,
    output logic [WIDTH-1:0]           rsp_dout,
    output logic                       err
);

    // Elaboration-time sanity checks on the parameter set.
    if (NUMWRPT != 2) begin : gBadNumWrPt
        $error("algo_1r2wg_req_sched supports exactly two write ports");
    end
    if (RD_DELAY < 1) begin : gBadRdDelay
        $error("algo_1r2wg_req_sched needs RD_DELAY of at least 1");
    end
    if (NUMADDR > (1 << BITADDR)) begin : gBadAddr
        $error("algo_1r2wg_req_sched: BITADDR too narrow for NUMADDR");
    end

    logic [NUMREQ-1:0]  legalRd;
    logic [NUMREQ-1:0]  legalWr;
    logic [NUMREQ-1:0]  illegalReq;

    logic [BITREQ-1:0]  rdPtr;
    logic [BITREQ-1:0]  wrPtr;

    logic               rdFound;
    logic [BITREQ-1:0]  rdIdx;
    logic               w0Found;
    logic [BITREQ-1:0]  w0Idx;
    logic [BITADDR-1:0] w0Adr;
    logic               w1Found;
    logic [BITREQ-1:0]  w1Idx;

    logic [BITREQ-1:0]  readTag;
    logic [RD_DELAY-1:0] tagVld;
    logic [BITREQ-1:0]  tagIdx [RD_DELAY];
    logic               lastVld;
    logic [BITREQ-1:0]  lastTag;

    // A requester asking to read and write at once is malformed and is never served.
    assign illegalReq = rq_read & rq_write;
    assign legalRd    = rq_read & ~rq_write;
    assign legalWr    = rq_write & ~rq_read;

    // Round-robin search for the read winner and the two write winners.
    always_comb begin
        int idx;
        idx     = 0;
        rdFound = 1'b0;
        rdIdx   = '0;
        w0Found = 1'b0;
        w0Idx   = '0;
        w0Adr   = '0;
        w1Found = 1'b0;
        w1Idx   = '0;
        for (int k = 0; k < NUMREQ; k++) begin
            idx = (int'(rdPtr) + k) % NUMREQ;
            if (!rdFound && legalRd[idx]) begin
                rdFound = 1'b1;
                rdIdx   = BITREQ'(idx);
            end
        end
        for (int k = 0; k < NUMREQ; k++) begin
            idx = (int'(wrPtr) + k) % NUMREQ;
            if (!w0Found && legalWr[idx]) begin
                w0Found = 1'b1;
                w0Idx   = BITREQ'(idx);
            end
        end
        w0Adr = rq_adr[int'(w0Idx)*BITADDR +: BITADDR];
        for (int k = 1; k < NUMREQ; k++) begin
            idx = (int'(w0Idx) + k) % NUMREQ;
            if (w0Found && !w1Found && legalWr[idx] &&
                (rq_adr[idx*BITADDR +: BITADDR] != w0Adr)) begin
                w1Found = 1'b1;
                w1Idx   = BITREQ'(idx);
            end
        end
    end

    // Grants are combinational and suppressed entirely while the memory is busy.
    always_comb begin
        rq_gnt = '0;
        if (ready) begin
            if (rdFound) rq_gnt[rdIdx] = 1'b1;
            if (w0Found) rq_gnt[w0Idx] = 1'b1;
            if (w1Found) rq_gnt[w1Idx] = 1'b1;
        end
    end

    // Advance each round-robin pointer past the last requester it served.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdPtr <= '0;
            wrPtr <= '0;
        end else if (ready) begin
            if (rdFound)
                rdPtr <= BITREQ'((int'(rdIdx) + 1) % NUMREQ);
            if (w1Found)
                wrPtr <= BITREQ'((int'(w1Idx) + 1) % NUMREQ);
            else if (w0Found)
                wrPtr <= BITREQ'((int'(w0Idx) + 1) % NUMREQ);
        end
    end

    // Register the granted read onto the memory read port, remembering its owner.
    always_ff @(posedge clk) begin
        if (rst) begin
            read    <= 1'b0;
            rd_adr  <= '0;
            readTag <= '0;
        end else begin
            read <= ready & rdFound;
            if (ready && rdFound) begin
                rd_adr  <= rq_adr[int'(rdIdx)*BITADDR +: BITADDR];
                readTag <= rdIdx;
            end
        end
    end

    // Register the granted writes; idle ports keep their last address and data.
    always_ff @(posedge clk) begin
        if (rst) begin
            write  <= '0;
            wr_adr <= '0;
            din    <= '0;
        end else begin
            write[0] <= ready & w0Found;
            write[1] <= ready & w1Found;
            if (ready && w0Found) begin
                wr_adr[0 +: BITADDR] <= w0Adr;
                din[0 +: WIDTH]      <= rq_din[int'(w0Idx)*WIDTH +: WIDTH];
            end
            if (ready && w1Found) begin
                wr_adr[BITADDR +: BITADDR] <= rq_adr[int'(w1Idx)*BITADDR +: BITADDR];
                din[WIDTH +: WIDTH]        <= rq_din[int'(w1Idx)*WIDTH +: WIDTH];
            end
        end
    end

    // Tag pipeline follows each issued read until the memory returns it.
    always_ff @(posedge clk) begin
        if (rst) begin
            tagVld <= '0;
            for (int k = 0; k < RD_DELAY; k++) tagIdx[k] <= '0;
        end else begin
            tagVld[0] <= read;
            tagIdx[0] <= readTag;
            for (int k = 1; k < RD_DELAY; k++) begin
                tagVld[k] <= tagVld[k-1];
                tagIdx[k] <= tagIdx[k-1];
            end
        end
    end

    assign lastVld  = tagVld[RD_DELAY-1];
    assign lastTag  = tagIdx[RD_DELAY-1];
    assign rsp_dout = rd_dout;

    // Steer a matching read return to the requester that owns it.
    always_comb begin
        rsp_vld = '0;
        if (!rst && rd_vld && lastVld) rsp_vld[lastTag] = 1'b1;
    end

    // Sticky error for malformed requests or returns that disagree with the tags.
    always_ff @(posedge clk) begin
        if (rst)
            err <= 1'b0;
        else if ((|illegalReq) || (rd_vld != lastVld))
            err <= 1'b1;
    end

endmodule

// File: tb/tb_algo_1r2wg_req_sched.sv
// Self-checking bench for algo_1r2wg_req_sched with a small memory model
// that returns read data RD_DELAY cycles after each issued read.
module tb_algo_1r2wg_req_sched;

    localparam int WIDTH    = 32;
    localparam int NUMADDR  = 8192;
    localparam int BITADDR  = 13;
    localparam int NUMWRPT  = 2;
    localparam int NUMREQ   = 4;
    localparam int BITREQ   = 2;
    localparam int RD_DELAY = 2;

    logic                       clk;
    logic                       rst;
    logic                       ready;
    logic [NUMREQ-1:0]          rq_read;
    logic [NUMREQ-1:0]          rq_write;
    logic [NUMREQ*BITADDR-1:0]  rq_adr;
    logic [NUMREQ*WIDTH-1:0]    rq_din;
    logic [NUMREQ-1:0]          rq_gnt;
    logic                       read;
    logic [BITADDR-1:0]         rd_adr;
    logic [NUMWRPT-1:0]         write;
    logic [NUMWRPT*BITADDR-1:0] wr_adr;
    logic [NUMWRPT*WIDTH-1:0]   din;
    logic                       rd_vld;
    logic [WIDTH-1:0]           rd_dout;
    logic [NUMREQ-1:0]          rsp_vld;
    logic [WIDTH-1:0]           rsp_dout;
    logic                       err;

    int nAssert = 0;
    int nFail   = 0;

    algo_1r2wg_req_sched #(
        .WIDTH(WIDTH), .NUMADDR(NUMADDR), .BITADDR(BITADDR), .NUMWRPT(NUMWRPT),
        .NUMREQ(NUMREQ), .BITREQ(BITREQ), .RD_DELAY(RD_DELAY)
    ) dut (
        .clk(clk), .rst(rst), .ready(ready),
        .rq_read(rq_read), .rq_write(rq_write), .rq_adr(rq_adr), .rq_din(rq_din),
        .rq_gnt(rq_gnt), .read(read), .rd_adr(rd_adr), .write(write),
        .wr_adr(wr_adr), .din(din), .rd_vld(rd_vld), .rd_dout(rd_dout),
        .rsp_vld(rsp_vld), .rsp_dout(rsp_dout), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: contents start as 0xC0DE0000|addr, writes land at the clock edge.
    logic [WIDTH-1:0] mem [NUMADDR];
    logic [1:0]       mRdPipe = 2'b00;
    logic [WIDTH-1:0] mData0  = '0;
    logic [WIDTH-1:0] mData1  = '0;

    initial begin
        for (int a = 0; a < NUMADDR; a++) mem[a] = 32'hC0DE_0000 | a;
    end

    // Model read latency and write ports of the memory.
    always @(posedge clk) begin
        mRdPipe <= {mRdPipe[0], read};
        mData1  <= mData0;
        mData0  <= mem[rd_adr];
        if (write[0] === 1'b1) mem[wr_adr[0 +: BITADDR]] <= din[0 +: WIDTH];
        if (write[1] === 1'b1) mem[wr_adr[BITADDR +: BITADDR]] <= din[WIDTH +: WIDTH];
    end

    assign rd_vld  = mRdPipe[1];
    assign rd_dout = mData1;

    typedef struct packed {
        logic               rdy;
        logic [3:0]         rdReq;
        logic [3:0]         wrReq;
        logic [BITADDR-1:0] a0;
        logic [BITADDR-1:0] a1;
        logic [BITADDR-1:0] a2;
        logic [BITADDR-1:0] a3;
        logic [3:0]         expGnt;
        logic               expRead;
        logic [BITADDR-1:0] expRdAdr;
        logic [1:0]         expWrite;
        logic [BITADDR-1:0] expWa0;
        logic [BITADDR-1:0] expWa1;
        logic [WIDTH-1:0]   expD0;
        logic [WIDTH-1:0]   expD1;
    } vecRecT;

    localparam logic [WIDTH-1:0] D0 = 32'hDA7A_0000;
    localparam logic [WIDTH-1:0] D1 = 32'hDA7A_0001;
    localparam logic [WIDTH-1:0] D2 = 32'hDA7A_0002;
    localparam logic [WIDTH-1:0] D3 = 32'hDA7A_0003;

    vecRecT vecs [16];

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] want);
        nAssert++;
        if (act !== want) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endtask

    task automatic applyStimulus(input vecRecT v);
        ready    = v.rdy;
        rq_read  = v.rdReq;
        rq_write = v.wrReq;
        rq_adr   = {v.a3, v.a2, v.a1, v.a0};
        #2;
    endtask

    task automatic checkOutput(input vecRecT v, input int i);
        checkVal($sformatf("v%0d rq_gnt", i), 64'(rq_gnt), 64'(v.expGnt));
        @(posedge clk);
        #1;
        checkVal($sformatf("v%0d read", i), 64'(read), 64'(v.expRead));
        if (v.expRead) checkVal($sformatf("v%0d rd_adr", i), 64'(rd_adr), 64'(v.expRdAdr));
        checkVal($sformatf("v%0d write", i), 64'(write), 64'(v.expWrite));
        if (v.expWrite[0]) begin
            checkVal($sformatf("v%0d wr_adr0", i), 64'(wr_adr[0 +: BITADDR]), 64'(v.expWa0));
            checkVal($sformatf("v%0d din0", i), 64'(din[0 +: WIDTH]), 64'(v.expD0));
        end
        if (v.expWrite[1]) begin
            checkVal($sformatf("v%0d wr_adr1", i), 64'(wr_adr[BITADDR +: BITADDR]), 64'(v.expWa1));
            checkVal($sformatf("v%0d din1", i), 64'(din[WIDTH +: WIDTH]), 64'(v.expD1));
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // rdy, rdReq, wrReq, a0, a1, a2, a3, expGnt, expRead, expRdAdr, expWrite, expWa0, expWa1, expD0, expD1
        vecs[0]  = '{1'b0, 4'b0000, 4'b1111, 13'h10, 13'h11, 13'h12, 13'h13, 4'b0000, 1'b0, 13'h0,  2'b00, 13'h0,  13'h0,  D0, D0};
        vecs[1]  = '{1'b1, 4'b0000, 4'b1111, 13'h10, 13'h11, 13'h12, 13'h13, 4'b0011, 1'b0, 13'h0,  2'b11, 13'h10, 13'h11, D0, D1};
        vecs[2]  = '{1'b1, 4'b0000, 4'b1100, 13'h10, 13'h11, 13'h12, 13'h13, 4'b1100, 1'b0, 13'h0,  2'b11, 13'h12, 13'h13, D2, D3};
        vecs[3]  = '{1'b1, 4'b0000, 4'b1001, 13'h40, 13'h0,  13'h0,  13'h43, 4'b1001, 1'b0, 13'h0,  2'b11, 13'h40, 13'h43, D0, D3};
        vecs[4]  = '{1'b1, 4'b0000, 4'b0011, 13'h55, 13'h55, 13'h0,  13'h0,  4'b0001, 1'b0, 13'h0,  2'b01, 13'h55, 13'h0,  D0, D0};
        vecs[5]  = '{1'b1, 4'b0000, 4'b0010, 13'h0,  13'h55, 13'h0,  13'h0,  4'b0010, 1'b0, 13'h0,  2'b01, 13'h55, 13'h0,  D1, D0};
        vecs[6]  = '{1'b1, 4'b0000, 4'b0101, 13'h60, 13'h0,  13'h62, 13'h0,  4'b0101, 1'b0, 13'h0,  2'b11, 13'h62, 13'h60, D2, D0};
        vecs[7]  = '{1'b1, 4'b0000, 4'b0000, 13'h0,  13'h0,  13'h0,  13'h0,  4'b0000, 1'b0, 13'h0,  2'b00, 13'h0,  13'h0,  D0, D0};
        vecs[8]  = '{1'b1, 4'b0001, 4'b0110, 13'h70, 13'h71, 13'h72, 13'h0,  4'b0111, 1'b1, 13'h70, 2'b11, 13'h71, 13'h72, D1, D2};
        vecs[9]  = '{1'b0, 4'b0000, 4'b1001, 13'h80, 13'h0,  13'h0,  13'h83, 4'b0000, 1'b0, 13'h0,  2'b00, 13'h0,  13'h0,  D0, D0};
        vecs[10] = '{1'b1, 4'b0000, 4'b1001, 13'h80, 13'h0,  13'h0,  13'h83, 4'b1001, 1'b0, 13'h0,  2'b11, 13'h83, 13'h80, D3, D0};
        vecs[11] = '{1'b1, 4'b1111, 4'b0000, 13'h90, 13'h91, 13'h92, 13'h93, 4'b0010, 1'b1, 13'h91, 2'b00, 13'h0,  13'h0,  D0, D0};
        vecs[12] = '{1'b1, 4'b0101, 4'b0000, 13'hA0, 13'h0,  13'hA2, 13'h0,  4'b0100, 1'b1, 13'hA2, 2'b00, 13'h0,  13'h0,  D0, D0};
        vecs[13] = '{1'b1, 4'b0001, 4'b0000, 13'hA0, 13'h0,  13'h0,  13'h0,  4'b0001, 1'b1, 13'hA0, 2'b00, 13'h0,  13'h0,  D0, D0};
        vecs[14] = '{1'b1, 4'b0000, 4'b0000, 13'h0,  13'h0,  13'h0,  13'h0,  4'b0000, 1'b0, 13'h0,  2'b00, 13'h0,  13'h0,  D0, D0};
        vecs[15] = '{1'b1, 4'b0000, 4'b0000, 13'h0,  13'h0,  13'h0,  13'h0,  4'b0000, 1'b0, 13'h0,  2'b00, 13'h0,  13'h0,  D0, D0};

        rst      = 1'b1;
        ready    = 1'b0;
        rq_read  = '0;
        rq_write = '0;
        rq_adr   = '0;
        for (int i = 0; i < NUMREQ; i++) rq_din[i*WIDTH +: WIDTH] = 32'hDA7A_0000 | i;

        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;

        // Reset state.
        checkVal("reset rq_gnt", 64'(rq_gnt), 64'h0);
        checkVal("reset read", 64'(read), 64'h0);
        checkVal("reset write", 64'(write), 64'h0);
        checkVal("reset rd_adr", 64'(rd_adr), 64'h0);
        checkVal("reset wr_adr", 64'(wr_adr), 64'h0);
        checkVal("reset din", 64'(din), 64'h0);
        checkVal("reset rsp_vld", 64'(rsp_vld), 64'h0);
        checkVal("reset err", 64'(err), 64'h0);

        // Table-driven arbitration vectors.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], i);
        end

        // Read return steering: requester 1 then requester 3.
        ready    = 1'b1;
        rq_write = '0;
        rq_read  = 4'b1010;
        rq_adr   = {13'h30, 13'h0, 13'h20, 13'h0};
        #2;
        checkVal("rdseq t gnt", 64'(rq_gnt), 64'b0010);
        stepCycle();
        rq_read = 4'b1000;
        #1;
        checkVal("rdseq t+1 gnt", 64'(rq_gnt), 64'b1000);
        checkVal("rdseq t+1 read", 64'(read), 64'h1);
        checkVal("rdseq t+1 rd_adr", 64'(rd_adr), 64'h20);
        stepCycle();
        rq_read = 4'b0000;
        #1;
        checkVal("rdseq t+2 read", 64'(read), 64'h1);
        checkVal("rdseq t+2 rd_adr", 64'(rd_adr), 64'h30);
        checkVal("rdseq t+2 rsp_vld", 64'(rsp_vld), 64'h0);
        stepCycle();
        checkVal("rdseq t+3 rsp_vld", 64'(rsp_vld), 64'b0010);
        checkVal("rdseq t+3 rsp_dout", 64'(rsp_dout), 64'hC0DE_0020);
        stepCycle();
        checkVal("rdseq t+4 rsp_vld", 64'(rsp_vld), 64'b1000);
        checkVal("rdseq t+4 rsp_dout", 64'(rsp_dout), 64'hC0DE_0030);
        stepCycle();
        checkVal("rdseq t+5 rsp_vld", 64'(rsp_vld), 64'h0);
        checkVal("rdseq err clear", 64'(err), 64'h0);

        // Illegal request on requester 2: never granted, err sticks.
        rq_read  = 4'b0100;
        rq_write = 4'b0100;
        rq_adr   = {13'h0, 13'h44, 13'h0, 13'h0};
        #2;
        checkVal("illegal gnt c0", 64'(rq_gnt), 64'h0);
        for (int c = 1; c <= 2; c++) begin
            stepCycle();
            checkVal($sformatf("illegal gnt c%0d", c), 64'(rq_gnt), 64'h0);
            checkVal($sformatf("illegal err c%0d", c), 64'(err), 64'h1);
            checkVal($sformatf("illegal write c%0d", c), 64'(write), 64'h0);
            checkVal($sformatf("illegal read c%0d", c), 64'(read), 64'h0);
        end
        rq_read  = '0;
        rq_write = '0;
        repeat (2) stepCycle();
        checkVal("illegal err sticky", 64'(err), 64'h1);

        // Reset with a read in flight: its return is dropped and flagged as spurious.
        rq_read = 4'b0001;
        rq_adr  = {13'h0, 13'h0, 13'h0, 13'h05};
        #2;
        checkVal("rstseq gnt", 64'(rq_gnt), 64'b0001);
        stepCycle();
        checkVal("rstseq read", 64'(read), 64'h1);
        rq_read = '0;
        rst     = 1'b1;
        stepCycle();
        rst = 1'b0;
        #1;
        checkVal("rstseq err after rst", 64'(err), 64'h0);
        checkVal("rstseq read after rst", 64'(read), 64'h0);
        checkVal("rstseq rsp_vld after rst", 64'(rsp_vld), 64'h0);
        stepCycle();
        checkVal("rstseq rsp_vld spurious", 64'(rsp_vld), 64'h0);
        stepCycle();
        checkVal("rstseq err spurious", 64'(err), 64'h1);
        checkVal("rstseq rsp_vld later", 64'(rsp_vld), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
